// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional counters: PIPE_PERF_CNT_EN)
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  id_branch_taken_i,
    input  logic                  mem_req_i,
    input  logic                  dcache_hit_i,
    input  logic                  dcache_ack_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  mem_stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      hazard_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MISS = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic miss;
    logic load_use;

    assign miss     = mem_req_i & ~dcache_hit_i;
    assign load_use = ex_memread_i
                    & (ex_rd_addr_i != '0)
                    & ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));

    // State register; reset or a stopped CPU parks the cache handshake in RUN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and prioritised pipeline controls (stall > load-use > branch > run)
    always_comb begin
        state_next    = state;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        mem_stall_o   = 1'b0;

        if (rst_i || !start_i) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (miss) begin
                        mem_stall_o = 1'b1;
                        state_next  = ST_MISS;
                    end
                end
                ST_MISS: begin
                    // Freeze holds through the ack cycle; release happens in DONE
                    mem_stall_o = 1'b1;
                    if (dcache_ack_i) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Refill data is valid here, so the hit flag is not consulted
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase

            if (mem_stall_o) begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
            end else if (load_use) begin
                // Any taken branch in ID is dropped; it resolves again next cycle
                idex_bubble_o = 1'b1;
            end else if (id_branch_taken_i) begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
                ifid_flush_o  = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] hazard_cnt;

    // Saturating performance counters; only reset clears them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt  <= '0;
            hazard_cnt <= '0;
        end else begin
            if (mem_stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (idex_bubble_o && (hazard_cnt != {CNT_W{1'b1}})) begin
                hazard_cnt <= hazard_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt;
    assign hazard_cnt_o = hazard_cnt;
`else
    assign stall_cnt_o  = '0;
    assign hazard_cnt_o = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write-enable, flush and bubble controls of the IF/ID and ID/EX registers.
- Drives the global mem_stall freeze consumed by every pipeline register.
- Detects load-use hazards, taken-branch flushes and data-cache misses; a small FSM handshakes with the data cache so MEM-stage accesses resolve before the pipe advances.

Parameters:
- REG_ADDR_W, 5, width of register-file addresses.
- CNT_W, 32, width of performance counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- start_i  in  1  CPU run enable; low holds the pipe idle.
- id_rs1_addr_i  in  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2_addr_i  in  REG_ADDR_W  rs2 of the instruction in ID.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rd_addr_i  in  REG_ADDR_W  rd of the instruction in EX.
- id_branch_taken_i  in  1  branch resolved taken in ID.
- mem_req_i  in  1  MEM stage issues a load or store this cycle.
- dcache_hit_i  in  1  data cache hit for the current MEM access.
- dcache_ack_i  in  1  cache refill/write-back complete (1-cycle pulse).
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  IF/ID clear to NOP.
- idex_bubble_o  out  1  zero ID/EX control fields (insert NOP).
- mem_stall_o  out  1  freeze every pipeline register.
- stall_cnt_o  out  CNT_W  cycles with mem_stall_o high.
- hazard_cnt_o  out  CNT_W  load-use bubbles inserted.

Behaviour:
- FSM states: RUN, MISS, DONE. Reset state RUN.
- RUN:
  - miss = mem_req_i & ~dcache_hit_i.
  - If miss, mem_stall_o=1 in the same cycle (combinational) and next state is MISS.
  - Else stay in RUN.
- MISS:
  - mem_stall_o=1 every cycle.
  - On dcache_ack_i=1, mem_stall_o stays 1 for that cycle and next state is DONE.
  - No timeout.
- DONE:
  - Exactly one cycle; mem_stall_o=0.
  - dcache_hit_i is ignored (refill data valid) so the MEM instruction retires.
  - Next state RUN.
- dcache_ack_i outside MISS is ignored.
- Load-use detection: lu = ex_memread_i & (ex_rd_addr_i != 0) & (ex_rd_addr_i == id_rs1_addr_i | ex_rd_addr_i == id_rs2_addr_i).
- Output priority, highest first:
  1. rst_i=1 or start_i=0: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, mem_stall_o=0. FSM forced/held in RUN.
  2. mem_stall_o=1: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0 (full freeze, no bubble).
  3. lu=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0. A simultaneous taken branch is suppressed; it re-resolves next cycle.
  4. id_branch_taken_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=0.
  5. Otherwise: pc_write_o=1, ifid_write_o=1, others 0.
- All outputs above are combinational from state and inputs. Only the state and counters are registered.
- Counters (see Optional Feature):
  - stall_cnt_o increments on every cycle with mem_stall_o=1.
  - hazard_cnt_o increments on every cycle with idex_bubble_o=1.
  - Both saturate at all-ones; no wrap.
  - Both cleared only by rst_i; they hold while start_i=0.
- Reset mid-miss: state returns to RUN on the next edge; mem_stall_o is 0 during and after reset. Any outstanding cache transaction is the cache's responsibility.
- Back-to-back misses: DONE always returns to RUN, even with mem_req_i & ~dcache_hit_i in DONE. A miss on the following instruction is detected in RUN of the next cycle.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: stall_cnt_o and hazard_cnt_o registers implemented as above.
- Undefined: no counter flops; both outputs are constant 0; ports remain present.

Test Plan:
- Reset/start: rst_i=1 for 2 cycles, then start_i=0 → all control outputs 0, state RUN, counters 0. Raise start_i → pc_write_o=1, ifid_write_o=1.
- Load-use: ex_memread_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, one cycle → pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; hazard_cnt_o=1. Same stimulus with ex_rd_addr_i=0 → no bubble.
- Branch: id_branch_taken_i=1, no hazard → ifid_flush_o=1, pc_write_o=1. With lu also active → ifid_flush_o=0, idex_bubble_o=1.
- Miss: mem_req_i=1, dcache_hit_i=0 at cycle 10, dcache_ack_i at cycle 14 → mem_stall_o=1 cycles 10–14, 0 at cycle 15 (DONE) regardless of hit. stall_cnt_o=5.
- Stall priority: a miss pending plus lu and branch active → only mem_stall_o=1; bubble, flush and pc_write all 0.
- Reset mid-miss: rst_i=1 at MISS cycle 2 → mem_stall_o=0 that cycle and after. A later dcache_ack_i is ignored and the next miss is handled normally.
